// File: rtl/pll_sweep_seq.sv
// pll_sweep_seq
// Steps a PLL through a table of frequency settings by driving the Altera
// pll_reconfig management port. Each reconfiguration writes the M/K/C
// counters, pulses pll_reset, waits for lock and then applies any phase
// offset relative to the phase the PLL holds after reset.
//
// Ports
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_cfg_table           entry e = {Ph,C,K,M}, 32 bits each, M at [e*128+:32]
//   i_cmd_valid/o_cmd_ready, i_cmd_op, i_cmd_index   command interface
//                         (0 up, 1 down, 2 reapply, 3 auto start,
//                          4 phase+, 5 phase-, 6 goto)
//   i_fail                tester failure flag for automatic stepping
//   i_locked              PLL lock indication
//   i_mgmt_waitrequest, o_mgmt_write, o_mgmt_address, o_mgmt_writedata
//                         Avalon-MM write master into pll_reconfig
//   o_pll_reset           PLL reset pulse
//   o_busy, o_done, o_lock_err   progress / completion / lock timeout
//   o_pos, o_phase_tgt, o_auto_mode, o_phase_mode   current settings
module pll_sweep_seq #(
  parameter int N_ENTRIES    = 11,
  parameter int N_OUTCLK     = 2,
  parameter int PH_BASE      = 29,
  parameter int PH_CNT       = 1,
  parameter int PH_MAX       = 100,
  parameter int GAP          = 8,
  parameter int RST_LEN      = 8,
  parameter int LOCK_TIMEOUT = 1000000,
  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_ENTRIES*128-1:0] i_cfg_table,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [2:0]             i_cmd_op,
  input  logic [IW-1:0]          i_cmd_index,
  input  logic                   i_fail,
  input  logic                   i_locked,
  input  logic                   i_mgmt_waitrequest,
  output logic                   o_mgmt_write,
  output logic [5:0]             o_mgmt_address,
  output logic [31:0]            o_mgmt_writedata,
  output logic                   o_pll_reset,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_lock_err,
  output logic [IW-1:0]          o_pos,
  output logic [7:0]             o_phase_tgt,
  output logic                   o_auto_mode,
  output logic                   o_phase_mode
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_GAP, S_PRST, S_LOCKW, S_PHCALC, S_DONE
  } state_t;

  // Main write list: 4 fixed writes, one per output counter, 3 trailing.
  localparam int NMAIN = N_OUTCLK + 7;
  localparam logic [IW-1:0] LAST = IW'(N_ENTRIES - 1);

  state_t        r_state, w_stateNxt;
  logic [7:0]    r_wIdx, w_wIdxNxt;
  logic          r_phSeg, w_phSegNxt;
  logic          r_postRst, w_postRstNxt;
  logic [31:0]   r_cnt, w_cntNxt;
  logic [IW-1:0] r_pos, w_posNxt;
  logic [7:0]    r_phaseTgt, w_phaseTgtNxt;
  logic          r_autoMode, w_autoModeNxt;
  logic          r_phaseMode, w_phaseModeNxt;
  logic          r_lockErr, w_lockErrNxt;
  logic          w_start;

  logic [95:0]   w_mkc [N_ENTRIES];
  logic [7:0]    w_ph  [N_ENTRIES];
  logic [IW-1:0] w_posUp, w_posDn;
  logic signed [9:0] w_d;
  logic [9:0]    w_dU, w_mag;
  logic          w_neg;
  logic [31:0]   w_phWord;
  logic [5:0]    w_addr;
  logic [31:0]   w_data;
  logic          w_unused;

  // Unpack the flat table into {C,K,M} and the low 8 phase bits per entry.
  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_tbl
    assign w_mkc[e] = i_cfg_table[e*128 +: 96];
    assign w_ph[e]  = i_cfg_table[e*128+96 +: 8];
  end

  assign w_posUp = r_pos + 1'b1;
  assign w_posDn = r_pos - 1'b1;

  // Phase offset relative to the post-reset phase, as sign + magnitude.
  assign w_d      = $signed({2'b00, r_phaseTgt}) - 10'(PH_BASE);
  assign w_dU     = w_d;
  assign w_neg    = w_d[9];
  assign w_mag    = w_neg ? (~w_dU + 10'd1) : w_dU;
  assign w_phWord = {10'd0, w_neg, 5'(PH_CNT), 7'd0, w_mag[8:0]};
  assign w_unused = ^{i_cfg_table, w_mag[9]};

  // Address/data of the write selected by the list segment and index.
  always_comb begin
    w_addr = 6'd0;
    w_data = 32'd0;
    if (r_phSeg) begin
      if (r_wIdx == 8'd1) begin
        w_addr = 6'd6;
        w_data = w_phWord;
      end else if (r_wIdx == 8'd2) begin
        w_addr = 6'd2;
      end
    end else begin
      if (r_wIdx == 8'd1) begin
        w_addr = 6'd4;
        w_data = w_mkc[r_pos][31:0];
      end else if (r_wIdx == 8'd2) begin
        w_addr = 6'd7;
        w_data = w_mkc[r_pos][63:32];
      end else if (r_wIdx == 8'd3) begin
        w_addr = 6'd3;
        w_data = 32'h0001_0000;
      end else if (32'(r_wIdx) >= 4 && 32'(r_wIdx) < 4 + N_OUTCLK) begin
        w_addr = 6'd5;
        w_data = w_mkc[r_pos][95:64] | ((32'(r_wIdx) - 32'd4) << 18);
      end else if (32'(r_wIdx) == 4 + N_OUTCLK) begin
        w_addr = 6'd9;
        w_data = 32'd1;
      end else if (32'(r_wIdx) == 5 + N_OUTCLK) begin
        w_addr = 6'd8;
        w_data = 32'd7;
      end else if (32'(r_wIdx) == 6 + N_OUTCLK) begin
        w_addr = 6'd2;
      end
    end
  end

  // Next-state logic. Commands outrank the automatic step; any command that
  // actually changes something restarts the full write list at index 0.
  always_comb begin
    w_stateNxt     = r_state;
    w_wIdxNxt      = r_wIdx;
    w_phSegNxt     = r_phSeg;
    w_postRstNxt   = r_postRst;
    w_cntNxt       = r_cnt;
    w_posNxt       = r_pos;
    w_phaseTgtNxt  = r_phaseTgt;
    w_autoModeNxt  = r_autoMode;
    w_phaseModeNxt = r_phaseMode;
    w_lockErrNxt   = r_lockErr;
    w_start        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_op)
            3'd0: if (r_pos != LAST) begin
              w_posNxt = w_posUp; w_phaseTgtNxt = w_ph[w_posUp];
              w_phaseModeNxt = 1'b0; w_autoModeNxt = 1'b0; w_start = 1'b1;
            end
            3'd1: if (r_pos != '0) begin
              w_posNxt = w_posDn; w_phaseTgtNxt = w_ph[w_posDn];
              w_phaseModeNxt = 1'b0; w_autoModeNxt = 1'b0; w_start = 1'b1;
            end
            3'd2: begin
              if (!r_phaseMode) w_phaseTgtNxt = w_ph[r_pos];
              w_start = 1'b1;
            end
            3'd3: begin
              w_posNxt = '0; w_phaseTgtNxt = w_ph[0];
              w_phaseModeNxt = 1'b0; w_autoModeNxt = 1'b1; w_start = 1'b1;
            end
            3'd4: if (32'(r_phaseTgt) < PH_MAX) begin
              w_phaseTgtNxt = r_phaseTgt + 8'd1;
              w_phaseModeNxt = 1'b1; w_autoModeNxt = 1'b0; w_start = 1'b1;
            end
            3'd5: if (r_phaseTgt != 8'd0) begin
              w_phaseTgtNxt = r_phaseTgt - 8'd1;
              w_phaseModeNxt = 1'b1; w_autoModeNxt = 1'b0; w_start = 1'b1;
            end
            3'd6: if (32'(i_cmd_index) < N_ENTRIES) begin
              w_posNxt = i_cmd_index; w_phaseTgtNxt = w_ph[i_cmd_index];
              w_phaseModeNxt = 1'b0; w_autoModeNxt = 1'b0; w_start = 1'b1;
            end
            default: ;
          endcase
        end else if (r_autoMode && i_fail && r_pos != LAST) begin
          w_posNxt = w_posUp; w_phaseTgtNxt = w_ph[w_posUp];
          w_phaseModeNxt = 1'b0; w_start = 1'b1;
        end
        if (w_start) begin
          w_stateNxt = S_WR; w_wIdxNxt = 8'd0;
          w_phSegNxt = 1'b0; w_postRstNxt = 1'b0;
        end
      end
      S_WR: if (!i_mgmt_waitrequest) begin
        w_stateNxt = S_GAP; w_cntNxt = 32'(GAP - 1);
      end
      S_GAP: begin
        if (r_cnt != 32'd0) begin
          w_cntNxt = r_cnt - 32'd1;
        end else if (r_postRst) begin
          w_stateNxt = S_LOCKW; w_cntNxt = 32'd0; w_postRstNxt = 1'b0;
        end else if (r_phSeg && r_wIdx == 8'd2) begin
          w_stateNxt = S_DONE;
        end else if (!r_phSeg && 32'(r_wIdx) == NMAIN - 1) begin
          w_stateNxt = S_PRST; w_cntNxt = 32'(RST_LEN - 1);
        end else begin
          w_stateNxt = S_WR; w_wIdxNxt = r_wIdx + 8'd1;
        end
      end
      S_PRST: begin
        if (r_cnt != 32'd0) begin
          w_cntNxt = r_cnt - 32'd1;
        end else begin
          w_stateNxt = S_GAP; w_cntNxt = 32'(GAP - 1); w_postRstNxt = 1'b1;
        end
      end
      S_LOCKW: begin
        if (i_locked) begin
          w_stateNxt = S_PHCALC;
        end else if (r_cnt == 32'(LOCK_TIMEOUT - 1)) begin
          w_stateNxt = S_IDLE; w_lockErrNxt = 1'b1;
        end else begin
          w_cntNxt = r_cnt + 32'd1;
        end
      end
      S_PHCALC: begin
        if (w_d == 10'sd0) begin
          w_stateNxt = S_DONE;
        end else begin
          w_stateNxt = S_WR; w_phSegNxt = 1'b1; w_wIdxNxt = 8'd0;
        end
      end
      S_DONE: begin
        w_lockErrNxt = 1'b0;
        w_stateNxt = S_IDLE;
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  // State register; reset reloads the entry-0 phase straight from the table.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wIdx      <= 8'd0;
      r_phSeg     <= 1'b0;
      r_postRst   <= 1'b0;
      r_cnt       <= 32'd0;
      r_pos       <= '0;
      r_phaseTgt  <= w_ph[0];
      r_autoMode  <= 1'b0;
      r_phaseMode <= 1'b0;
      r_lockErr   <= 1'b0;
    end else begin
      r_state     <= w_stateNxt;
      r_wIdx      <= w_wIdxNxt;
      r_phSeg     <= w_phSegNxt;
      r_postRst   <= w_postRstNxt;
      r_cnt       <= w_cntNxt;
      r_pos       <= w_posNxt;
      r_phaseTgt  <= w_phaseTgtNxt;
      r_autoMode  <= w_autoModeNxt;
      r_phaseMode <= w_phaseModeNxt;
      r_lockErr   <= w_lockErrNxt;
    end
  end

  // Write strobe and PLL reset are gated by reset so an abort takes effect
  // in the cycle reset is raised rather than one edge later.
  assign o_cmd_ready      = (r_state == S_IDLE);
  assign o_mgmt_write     = (r_state == S_WR) && !i_reset;
  assign o_mgmt_address   = w_addr;
  assign o_mgmt_writedata = w_data;
  assign o_pll_reset      = (r_state == S_PRST) && !i_reset;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_lock_err       = r_lockErr;
  assign o_pos            = r_pos;
  assign o_phase_tgt      = r_phaseTgt;
  assign o_auto_mode      = r_autoMode;
  assign o_phase_mode     = r_phaseMode;

endmodule

// File: tb/tb_pll_sweep_seq.sv
// Testbench for pll_sweep_seq: directed command sequence with a write
// scoreboard fed by an independent model of the reconfiguration write list.
module tb_pll_sweep_seq;
  localparam int NE = 11, NO = 2, GAPC = 8, RSTL = 8, LTO = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cmdValid, cmdReady, fail, locked, waitreq;
  logic [2:0]        cmdOp;
  logic [3:0]        cmdIndex, pos;
  logic [NE*128-1:0] cfgTable;
  logic              mgmtWrite, pllReset, busy, done, lockErr, autoMode, phaseMode;
  logic [5:0]        mgmtAddr;
  logic [31:0]       mgmtData;
  logic [7:0]        phaseTgt;

  logic [31:0] tblM [NE];
  logic [31:0] tblK [NE];
  logic [31:0] tblC [NE];
  logic [31:0] tblPh [NE];

  int total = 0, bad = 0;
  logic [37:0] expQ [$];
  bit sbOn = 1'b1;
  int doneCount = 0, rstRun = 0, lastRstLen = 0, postRstCnt = 0;
  int d0, stable, n;

  pll_sweep_seq #(
    .N_ENTRIES(NE), .N_OUTCLK(NO), .PH_BASE(29), .PH_CNT(1), .PH_MAX(100),
    .GAP(GAPC), .RST_LEN(RSTL), .LOCK_TIMEOUT(LTO)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_cfg_table(cfgTable),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_op(cmdOp),
    .i_cmd_index(cmdIndex), .i_fail(fail), .i_locked(locked),
    .i_mgmt_waitrequest(waitreq), .o_mgmt_write(mgmtWrite),
    .o_mgmt_address(mgmtAddr), .o_mgmt_writedata(mgmtData),
    .o_pll_reset(pllReset), .o_busy(busy), .o_done(done),
    .o_lock_err(lockErr), .o_pos(pos), .o_phase_tgt(phaseTgt),
    .o_auto_mode(autoMode), .o_phase_mode(phaseMode)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: scoreboard accepted writes, count done pulses, measure the
  // pll_reset pulse and the busy time that follows it.
  always @(negedge clk) begin
    logic [37:0] e;
    if (mgmtWrite === 1'b1 && waitreq === 1'b0 && sbOn) begin
      if (expQ.size() != 0) e = expQ.pop_front();
      else e = '1;
      checkOutput("mgmt write", {26'd0, mgmtAddr, mgmtData}, {26'd0, e});
    end
    if (done === 1'b1) doneCount++;
    if (pllReset === 1'b1) begin
      rstRun++;
      postRstCnt = 0;
    end else begin
      if (rstRun != 0) lastRstLen = rstRun;
      rstRun = 0;
      if (busy === 1'b1) postRstCnt++;
    end
  end

  task automatic pushMain(input int e);
    expQ.push_back({6'd0, 32'd0});
    expQ.push_back({6'd4, tblM[e]});
    expQ.push_back({6'd7, tblK[e]});
    expQ.push_back({6'd3, 32'h0001_0000});
    for (int c = 0; c < NO; c++) expQ.push_back({6'd5, tblC[e] | (32'(c) << 18)});
    expQ.push_back({6'd9, 32'd1});
    expQ.push_back({6'd8, 32'd7});
    expQ.push_back({6'd2, 32'd0});
  endtask

  task automatic pushPhase(input int ph);
    int d;
    d = ph - 29;
    if (d != 0) begin
      expQ.push_back({6'd0, 32'd0});
      expQ.push_back({6'd6, 32'(d < 0 ? -d : d) | 32'h0001_0000 | (d < 0 ? 32'h0020_0000 : 32'd0)});
      expQ.push_back({6'd2, 32'd0});
    end
  endtask

  task automatic applyStimulus(input int op, input int idx);
    @(posedge clk); #1;
    cmdValid = 1'b1; cmdOp = 3'(op); cmdIndex = 4'(idx);
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  task automatic waitWrite(input logic [5:0] addr, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!(mgmtWrite === 1'b1 && mgmtAddr === addr) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("write seen", {57'd0, mgmtWrite, mgmtAddr}, {57'd1, addr});
  endtask

  initial begin
    for (int e = 0; e < NE; e++) begin
      tblM[e]  = 32'h100 + 32'(e);
      tblK[e]  = 32'h200 + 32'(e);
      tblC[e]  = 32'h300 + 32'(e);
      tblPh[e] = (e == 0) ? 32'd100 : (e == 1) ? 32'd28 : (e == 2) ? 32'd29 : 32'(20 + e);
      cfgTable[e*128 +: 128] = {tblPh[e], tblC[e], tblK[e], tblM[e]};
    end
    reset = 1'b1; cmdValid = 1'b0; cmdOp = 3'd0; cmdIndex = 4'd0;
    fail = 1'b0; locked = 1'b1; waitreq = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    checkOutput("rst cmd_ready", 64'(cmdReady), 64'd1);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst pos", 64'(pos), 64'd0);
    checkOutput("rst phase_tgt", 64'(phaseTgt), 64'd100);
    checkOutput("rst mgmt_write", 64'(mgmtWrite), 64'd0);
    checkOutput("rst pll_reset", 64'(pllReset), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkOutput("rst lock_err", 64'(lockErr), 64'd0);
    checkOutput("rst auto_mode", 64'(autoMode), 64'd0);
    checkOutput("rst phase_mode", 64'(phaseMode), 64'd0);

    // Ignored commands: phase+ at PH_MAX, down at entry 0
    applyStimulus(4, 0);
    @(negedge clk);
    checkOutput("ph+ at max busy", 64'(busy), 64'd0);
    checkOutput("ph+ at max tgt", 64'(phaseTgt), 64'd100);
    checkOutput("ph+ at max mode", 64'(phaseMode), 64'd0);
    applyStimulus(1, 0);
    @(negedge clk);
    checkOutput("down at 0 busy", 64'(busy), 64'd0);
    checkOutput("down at 0 pos", 64'(pos), 64'd0);
    checkOutput("ignored done", 64'(doneCount), 64'd0);

    // Up to entry 1 (Ph=28, negative phase step)
    d0 = doneCount;
    pushMain(1); pushPhase(28);
    applyStimulus(0, 0);
    waitIdle("up1", 3000);
    checkOutput("up1 done", 64'(doneCount - d0), 64'd1);
    checkOutput("up1 pos", 64'(pos), 64'd1);
    checkOutput("up1 phase_tgt", 64'(phaseTgt), 64'd28);
    checkOutput("up1 queue", 64'(expQ.size()), 64'd0);
    checkOutput("up1 rst len", 64'(lastRstLen), 64'(RSTL));

    // Up to entry 2 (Ph=PH_BASE, no phase writes)
    d0 = doneCount;
    pushMain(2); pushPhase(29);
    applyStimulus(0, 0);
    waitIdle("up2", 3000);
    checkOutput("up2 done", 64'(doneCount - d0), 64'd1);
    checkOutput("up2 pos", 64'(pos), 64'd2);
    checkOutput("up2 queue", 64'(expQ.size()), 64'd0);

    // Down to entry 1 with waitrequest stalling the K write for 5 cycles
    d0 = doneCount;
    pushMain(1); pushPhase(28);
    applyStimulus(1, 0);
    waitWrite(6'd4, 100);
    @(posedge clk); #1 waitreq = 1'b1;
    waitWrite(6'd7, 100);
    stable = 0;
    for (int k = 0; k < 6; k++) begin
      if (mgmtWrite === 1'b1 && mgmtAddr === 6'd7 && mgmtData === tblK[1]) stable++;
      @(posedge clk); #1;
      if (k == 4) waitreq = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall stable", 64'(stable), 64'd6);
    checkOutput("stall released", 64'(mgmtWrite), 64'd0);
    waitIdle("stall", 3000);
    checkOutput("stall done", 64'(doneCount - d0), 64'd1);
    checkOutput("stall queue", 64'(expQ.size()), 64'd0);

    // Lock timeout on goto 3
    d0 = doneCount;
    locked = 1'b0;
    pushMain(3);
    applyStimulus(6, 3);
    waitIdle("timeout", 4000);
    checkOutput("timeout lock_err", 64'(lockErr), 64'd1);
    checkOutput("timeout done", 64'(doneCount - d0), 64'd0);
    checkOutput("timeout pos", 64'(pos), 64'd3);
    checkOutput("timeout cycles", 64'(postRstCnt), 64'(GAPC + LTO));
    checkOutput("timeout queue", 64'(expQ.size()), 64'd0);
    checkOutput("timeout ready", 64'(cmdReady), 64'd1);

    // Out-of-range goto ignored
    applyStimulus(6, 11);
    @(negedge clk);
    checkOutput("goto oor busy", 64'(busy), 64'd0);
    checkOutput("goto oor pos", 64'(pos), 64'd3);

    // Reapply with lock restored clears lock_err
    locked = 1'b1;
    d0 = doneCount;
    pushMain(3); pushPhase(23);
    applyStimulus(2, 0);
    waitIdle("reapply", 3000);
    checkOutput("reapply lock_err", 64'(lockErr), 64'd0);
    checkOutput("reapply done", 64'(doneCount - d0), 64'd1);
    checkOutput("reapply queue", 64'(expQ.size()), 64'd0);

    // Phase trim, then reapply keeps the trimmed phase
    pushMain(3); pushPhase(24);
    applyStimulus(4, 0);
    waitIdle("ph+", 3000);
    pushMain(3); pushPhase(24);
    applyStimulus(2, 0);
    waitIdle("ph reapply", 3000);
    checkOutput("trim phase_tgt", 64'(phaseTgt), 64'd24);
    checkOutput("trim phase_mode", 64'(phaseMode), 64'd1);
    pushMain(3); pushPhase(23);
    applyStimulus(5, 0);
    waitIdle("ph-", 3000);
    checkOutput("ph- phase_tgt", 64'(phaseTgt), 64'd23);
    checkOutput("trim queue", 64'(expQ.size()), 64'd0);

    // Automatic stepping on fail
    sbOn = 1'b0;
    applyStimulus(3, 0);
    waitIdle("auto start", 3000);
    checkOutput("auto pos0", 64'(pos), 64'd0);
    checkOutput("auto mode", 64'(autoMode), 64'd1);
    d0 = doneCount;
    fail = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("auto cmd_ready", 64'(cmdReady), 64'd0);
    applyStimulus(1, 0);
    n = 0;
    while (!(pos === 4'd10 && busy === 1'b0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    checkOutput("auto end pos", 64'(pos), 64'd10);
    checkOutput("auto steps", 64'(doneCount - d0), 64'd10);
    checkOutput("auto end mode", 64'(autoMode), 64'd1);
    checkOutput("auto end busy", 64'(busy), 64'd0);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("up sat busy", 64'(busy), 64'd0);
    checkOutput("up sat pos", 64'(pos), 64'd10);
    fail = 1'b0;
    expQ.delete();

    // Reset during the gap after the M write
    d0 = doneCount;
    applyStimulus(1, 0);
    waitWrite(6'd4, 100);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort pll_reset", 64'(pllReset), 64'd0);
    @(negedge clk);
    checkOutput("abort mgmt_write", 64'(mgmtWrite), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort pos", 64'(pos), 64'd0);
    checkOutput("abort phase_tgt", 64'(phaseTgt), 64'd100);
    @(posedge clk); #1 reset = 1'b0;
    applyStimulus(4, 0);
    @(negedge clk);
    checkOutput("post abort ph+ busy", 64'(busy), 64'd0);
    checkOutput("post abort ph+ tgt", 64'(phaseTgt), 64'd100);
    checkOutput("abort done", 64'(doneCount - d0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
